// File: rtl/bsg_dmc_axi_mem_responder.sv
// AXI4 slave memory model for the far end of the DMC emulator's AXI master.
// It accepts write bursts (AW/W), returns write responses (B), and serves read
// bursts (AR/R) from an internal word array. The read and write engines are
// independent FSMs. Every beat is full width, and every burst is treated as INCR.
//
// Optional feature, macro BSG_DMC_AXI_MEM_BOUNDS_CHECK_EN:
//   When defined, a burst counts as out of range when its unwrapped start index
//   plus len runs past the last word. Such a burst answers SLVERR. Its writes are
//   dropped and its reads return zero. When undefined, the index wraps silently
//   and every response is OKAY.
module bsg_dmc_axi_mem_responder #(
  parameter  int axi_id_width_p    = 6,
  parameter  int axi_addr_width_p  = 32,
  parameter  int axi_data_width_p  = 64,
  parameter  int mem_els_p         = 1024,
  localparam int axi_strb_width_lp = axi_data_width_p >> 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [axi_id_width_p-1:0]    axi_awid_i,
  input  logic [axi_addr_width_p-1:0]  axi_awaddr_i,
  input  logic [7:0]                   axi_awlen_i,
  input  logic                         axi_awvalid_i,
  output logic                         axi_awready_o,

  input  logic [axi_data_width_p-1:0]  axi_wdata_i,
  input  logic [axi_strb_width_lp-1:0] axi_wstrb_i,
  input  logic                         axi_wlast_i,
  input  logic                         axi_wvalid_i,
  output logic                         axi_wready_o,

  output logic [axi_id_width_p-1:0]    axi_bid_o,
  output logic [1:0]                   axi_bresp_o,
  output logic                         axi_bvalid_o,
  input  logic                         axi_bready_i,

  input  logic [axi_id_width_p-1:0]    axi_arid_i,
  input  logic [axi_addr_width_p-1:0]  axi_araddr_i,
  input  logic [7:0]                   axi_arlen_i,
  input  logic                         axi_arvalid_i,
  output logic                         axi_arready_o,

  output logic [axi_id_width_p-1:0]    axi_rid_o,
  output logic [axi_data_width_p-1:0]  axi_rdata_o,
  output logic [1:0]                   axi_rresp_o,
  output logic                         axi_rlast_o,
  output logic                         axi_rvalid_o,
  input  logic                         axi_rready_i,

  output logic                         error_o
);

  localparam int         lg_strb_lp     = $clog2(axi_strb_width_lp);
  localparam int         lg_els_lp      = $clog2(mem_els_p);
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Word storage. The array is not reset.
  logic [axi_data_width_p-1:0] mem_q [mem_els_p];

  // Write engine state.
  w_state_e                    w_state_q, w_state_d;
  logic [axi_id_width_p-1:0]   w_id_q,    w_id_d;
  logic [lg_els_lp-1:0]        w_idx_q,   w_idx_d;
  logic [7:0]                  w_len_q,   w_len_d;
  logic [7:0]                  w_cnt_q,   w_cnt_d;
  logic                        w_oob_q,   w_oob_d;
  logic                        error_q,   error_d;
  logic                        mem_we;
  logic                        w_last_beat;

  // Read engine state.
  r_state_e                    r_state_q, r_state_d;
  logic [axi_id_width_p-1:0]   r_id_q,    r_id_d;
  logic [lg_els_lp-1:0]        r_idx_q,   r_idx_d;
  logic [7:0]                  r_len_q,   r_len_d;
  logic [7:0]                  r_cnt_q,   r_cnt_d;
  logic                        r_oob_q,   r_oob_d;
  logic                        r_last_beat;

  // Out-of-range flags for the burst now being offered on AW / AR.
  logic                        aw_oob;
  logic                        ar_oob;

  // The bytes below the word offset never matter. The bits above the index
  // matter only to the bounds check, so the whole address is folded here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

`ifdef BSG_DMC_AXI_MEM_BOUNDS_CHECK_EN
  localparam logic [axi_addr_width_p:0] max_idx_lp = (axi_addr_width_p+1)'(mem_els_p - 1);

  logic [axi_addr_width_p:0] aw_end_idx;
  logic [axi_addr_width_p:0] ar_end_idx;

  // The range test uses the unwrapped start index, so a burst that would wrap is caught.
  assign aw_end_idx = {1'b0, axi_awaddr_i >> lg_strb_lp}
                    + {{(axi_addr_width_p-7){1'b0}}, axi_awlen_i};
  assign ar_end_idx = {1'b0, axi_araddr_i >> lg_strb_lp}
                    + {{(axi_addr_width_p-7){1'b0}}, axi_arlen_i};
  assign aw_oob     = (aw_end_idx > max_idx_lp);
  assign ar_oob     = (ar_end_idx > max_idx_lp);
`else
  assign aw_oob     = 1'b0;
  assign ar_oob     = 1'b0;
`endif

  assign w_last_beat = (w_cnt_q == w_len_q);
  assign r_last_beat = (r_cnt_q == r_len_q);

  // Write engine: next state, latched burst fields, handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_d     = w_state_q;
    w_id_d        = w_id_q;
    w_idx_d       = w_idx_q;
    w_len_d       = w_len_q;
    w_cnt_d       = w_cnt_q;
    w_oob_d       = w_oob_q;
    error_d       = error_q;
    mem_we        = 1'b0;
    axi_awready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        axi_awready_o = 1'b1;
        if (axi_awvalid_i) begin
          w_id_d    = axi_awid_i;
          w_idx_d   = axi_awaddr_i[lg_strb_lp +: lg_els_lp];
          w_len_d   = axi_awlen_i;
          w_cnt_d   = 8'd0;
          w_oob_d   = aw_oob;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) begin
          mem_we  = ~w_oob_q;
          w_idx_d = w_idx_q + lg_els_lp'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          // The latched len ends the burst. A wlast in the wrong place only raises the flag.
          if (axi_wlast_i != w_last_beat) error_d = 1'b1;
          if (w_last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine registers. Reset abandons any burst in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_oob_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_oob_q   <= w_oob_d;
      error_q   <= error_d;
    end
  end

  // Byte-lane write into the word array on each accepted W beat.
  // NOTE: the memory has no reset; beats already written survive a mid-burst reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < axi_strb_width_lp; i++) begin
        if (axi_wstrb_i[i]) mem_q[w_idx_q][8*i +: 8] <= axi_wdata_i[8*i +: 8];
      end
    end
  end

  // Read engine: next state and latched burst fields.
  always_comb begin
    r_state_d     = r_state_q;
    r_id_d        = r_id_q;
    r_idx_d       = r_idx_q;
    r_len_d       = r_len_q;
    r_cnt_d       = r_cnt_q;
    r_oob_d       = r_oob_q;
    axi_arready_o = 1'b0;
    axi_rvalid_o  = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        axi_arready_o = 1'b1;
        if (axi_arvalid_i) begin
          r_id_d    = axi_arid_i;
          r_idx_d   = axi_araddr_i[lg_strb_lp +: lg_els_lp];
          r_len_d   = axi_arlen_i;
          r_cnt_d   = 8'd0;
          r_oob_d   = ar_oob;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) begin
          r_idx_d = r_idx_q + lg_els_lp'(1);
          r_cnt_d = r_cnt_q + 8'd1;
          if (r_last_beat) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_oob_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_oob_q   <= r_oob_d;
    end
  end

  // Response channels come straight from the registered state. The array is
  // read combinationally, so a write on the same edge shows up one cycle later.
  assign axi_bid_o   = w_id_q;
  assign axi_bresp_o = (axi_bvalid_o && w_oob_q) ? resp_slverr_lp : resp_okay_lp;

  assign axi_rid_o   = r_id_q;
  assign axi_rdata_o = (axi_rvalid_o && !r_oob_q) ? mem_q[r_idx_q] : '0;
  assign axi_rresp_o = (axi_rvalid_o && r_oob_q) ? resp_slverr_lp : resp_okay_lp;
  assign axi_rlast_o = axi_rvalid_o && r_last_beat;

  assign error_o     = error_q;

endmodule

// File: tb/tb_bsg_dmc_axi_mem_responder.sv
// Self-checking bench for bsg_dmc_axi_mem_responder. Expected B and R beats
// come from a bench-side memory model. They are queued when a request is
// issued and compared when the DUT presents them.
module tb_bsg_dmc_axi_mem_responder;

  localparam int id_w   = 6;
  localparam int addr_w = 32;
  localparam int data_w = 64;
  localparam int els    = 1024;
  localparam int strb_w = data_w >> 3;

  logic                clk = 1'b0;
  logic                reset_i = 1'b1;
  logic [id_w-1:0]     axi_awid_i = '0;
  logic [addr_w-1:0]   axi_awaddr_i = '0;
  logic [7:0]          axi_awlen_i = '0;
  logic                axi_awvalid_i = 1'b0;
  logic                axi_awready_o;
  logic [data_w-1:0]   axi_wdata_i = '0;
  logic [strb_w-1:0]   axi_wstrb_i = '0;
  logic                axi_wlast_i = 1'b0;
  logic                axi_wvalid_i = 1'b0;
  logic                axi_wready_o;
  logic [id_w-1:0]     axi_bid_o;
  logic [1:0]          axi_bresp_o;
  logic                axi_bvalid_o;
  logic                axi_bready_i = 1'b0;
  logic [id_w-1:0]     axi_arid_i = '0;
  logic [addr_w-1:0]   axi_araddr_i = '0;
  logic [7:0]          axi_arlen_i = '0;
  logic                axi_arvalid_i = 1'b0;
  logic                axi_arready_o;
  logic [id_w-1:0]     axi_rid_o;
  logic [data_w-1:0]   axi_rdata_o;
  logic [1:0]          axi_rresp_o;
  logic                axi_rlast_o;
  logic                axi_rvalid_o;
  logic                axi_rready_i = 1'b0;
  logic                error_o;

  always #5 clk = ~clk;

  bsg_dmc_axi_mem_responder #(
    .axi_id_width_p  (id_w),
    .axi_addr_width_p(addr_w),
    .axi_data_width_p(data_w),
    .mem_els_p       (els)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .axi_awid_i    (axi_awid_i),
    .axi_awaddr_i  (axi_awaddr_i),
    .axi_awlen_i   (axi_awlen_i),
    .axi_awvalid_i (axi_awvalid_i),
    .axi_awready_o (axi_awready_o),
    .axi_wdata_i   (axi_wdata_i),
    .axi_wstrb_i   (axi_wstrb_i),
    .axi_wlast_i   (axi_wlast_i),
    .axi_wvalid_i  (axi_wvalid_i),
    .axi_wready_o  (axi_wready_o),
    .axi_bid_o     (axi_bid_o),
    .axi_bresp_o   (axi_bresp_o),
    .axi_bvalid_o  (axi_bvalid_o),
    .axi_bready_i  (axi_bready_i),
    .axi_arid_i    (axi_arid_i),
    .axi_araddr_i  (axi_araddr_i),
    .axi_arlen_i   (axi_arlen_i),
    .axi_arvalid_i (axi_arvalid_i),
    .axi_arready_o (axi_arready_o),
    .axi_rid_o     (axi_rid_o),
    .axi_rdata_o   (axi_rdata_o),
    .axi_rresp_o   (axi_rresp_o),
    .axi_rlast_o   (axi_rlast_o),
    .axi_rvalid_o  (axi_rvalid_o),
    .axi_rready_i  (axi_rready_i),
    .error_o       (error_o)
  );

  typedef struct packed {
    logic [id_w-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  typedef struct packed {
    logic [id_w-1:0]   id;
    logic [data_w-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_exp_t;

  typedef struct packed {
    logic              awready, arready, wready, bvalid, rvalid, rlast, error;
    logic [id_w-1:0]   bid;
    logic [1:0]        bresp;
    logic [id_w-1:0]   rid;
    logic [1:0]        rresp;
    logic [data_w-1:0] rdata;
  } outs_t;

  localparam outs_t reset_outs = outs_t'({7'b1100000, 6'd0, 2'd0, 6'd0, 2'd0, 64'd0});

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [63:0] model_mem [els];
  logic [63:0] wbeats    [256];
  b_exp_t      b_q[$];
  r_exp_t      r_q[$];

  function automatic outs_t sample_outs();
    sample_outs = {axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o,
                   axi_rlast_o, error_o, axi_bid_o, axi_bresp_o, axi_rid_o, axi_rresp_o,
                   axi_rdata_o};
  endfunction

  function automatic logic burst_oob(input logic [31:0] addr, input int len);
    longint start_idx;
    start_idx = longint'(addr >> 3);
    burst_oob = 1'b0;
`ifdef BSG_DMC_AXI_MEM_BOUNDS_CHECK_EN
    burst_oob = (start_idx + longint'(len)) > longint'(els - 1);
`endif
    if (start_idx < 0) burst_oob = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one write burst using wbeats[0..len]. B is held off for b_hold
  // cycles. If pend_aw is set, a new AW is offered during that hold.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [id_w-1:0] id,
                          input logic [7:0] strb, input int b_hold, input int last_beat,
                          input bit pend_aw);
    logic   oob;
    int     n;
    int     idx;
    b_exp_t exp_b;
    b_exp_t obs_b;
    oob        = burst_oob(addr, len);
    exp_b.id   = id;
    exp_b.resp = oob ? 2'd2 : 2'd0;
    b_q.push_back(exp_b);
    axi_awid_i    = id;
    axi_awaddr_i  = addr;
    axi_awlen_i   = 8'(len);
    axi_awvalid_i = 1'b1;
    n = 0;
    while (axi_awready_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      total_cnt++;
      $display("FAIL aw_timeout awready=%b required 1", axi_awready_o);
    end
    tick();
    axi_awvalid_i = 1'b0;
    for (int b = 0; b <= len; b++) begin
      axi_wdata_i  = wbeats[b];
      axi_wstrb_i  = strb;
      axi_wlast_i  = (b == last_beat);
      axi_wvalid_i = 1'b1;
      n = 0;
      while (axi_wready_o !== 1'b1 && n < 50) begin tick(); n++; end
      if (n == 50) begin
        total_cnt++;
        $display("FAIL w_timeout beat=%0d wready=%b required 1", b, axi_wready_o);
      end
      tick();
      if (!oob) begin
        idx = int'((longint'(addr >> 3) + longint'(b)) % els);
        for (int k = 0; k < strb_w; k++)
          if (strb[k]) model_mem[idx][8*k +: 8] = wbeats[b][8*k +: 8];
      end
    end
    axi_wvalid_i = 1'b0;
    axi_wlast_i  = 1'b0;
    axi_bready_i = (b_hold == 0);
    n = 0;
    while (axi_bvalid_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      total_cnt++;
      $display("FAIL b_timeout bvalid=%b required 1", axi_bvalid_o);
    end
    exp_b = b_q.pop_front();
    obs_b = {axi_bid_o, axi_bresp_o};
    total_cnt++;
    if (obs_b !== exp_b) $display("FAIL b_resp got id=%h resp=%0d want id=%h resp=%0d",
                                  obs_b.id, obs_b.resp, exp_b.id, exp_b.resp);
    else pass_cnt++;
    for (int h = 0; h < b_hold; h++) begin
      if (pend_aw) axi_awvalid_i = 1'b1;
      total_cnt++;
      if ({axi_bvalid_o, axi_awready_o} !== 2'b10)
        $display("FAIL b_hold cycle=%0d got bvalid,awready=%b%b want 10",
                 h, axi_bvalid_o, axi_awready_o);
      else pass_cnt++;
      tick();
    end
    axi_bready_i = 1'b1;
    tick();
    axi_bready_i = 1'b0;
  endtask

  // Issue one read burst and score every beat. With stall set, rready toggles
  // each cycle, and every stalled beat must hold steady into the next cycle.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [id_w-1:0] id,
                         input bit stall);
    logic   oob;
    int     n;
    int     idx;
    int     beats;
    int     cyc;
    int     last_cnt;
    bit     have_prev;
    r_exp_t exp_r;
    r_exp_t obs_r;
    r_exp_t prev_r;
    oob = burst_oob(addr, len);
    for (int b = 0; b <= len; b++) begin
      idx        = int'((longint'(addr >> 3) + longint'(b)) % els);
      exp_r.id   = id;
      exp_r.data = oob ? 64'd0 : model_mem[idx];
      exp_r.resp = oob ? 2'd2 : 2'd0;
      exp_r.last = (b == len);
      r_q.push_back(exp_r);
    end
    axi_arid_i    = id;
    axi_araddr_i  = addr;
    axi_arlen_i   = 8'(len);
    axi_arvalid_i = 1'b1;
    n = 0;
    while (axi_arready_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      total_cnt++;
      $display("FAIL ar_timeout arready=%b required 1", axi_arready_o);
    end
    tick();
    axi_arvalid_i = 1'b0;
    total_cnt++;
    if (axi_rvalid_o !== 1'b1) $display("FAIL r_first_beat_latency rvalid=%b want 1", axi_rvalid_o);
    else pass_cnt++;
    beats     = 0;
    cyc       = 0;
    last_cnt  = 0;
    have_prev = 1'b0;
    prev_r    = '0;
    while (beats <= len && cyc < 400) begin
      axi_rready_i = stall ? cyc[0] : 1'b1;
      if (axi_rvalid_o === 1'b1) begin
        obs_r = {axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o};
        if (have_prev) begin
          total_cnt++;
          if (obs_r !== prev_r) $display("FAIL r_stall_stable beat=%0d got=%h want=%h",
                                         beats, obs_r, prev_r);
          else pass_cnt++;
        end
        if (axi_rready_i) begin
          exp_r = r_q.pop_front();
          total_cnt++;
          if (obs_r !== exp_r) $display("FAIL r_beat%0d got id=%h data=%h resp=%0d last=%b want id=%h data=%h resp=%0d last=%b",
                                        beats, obs_r.id, obs_r.data, obs_r.resp, obs_r.last,
                                        exp_r.id, exp_r.data, exp_r.resp, exp_r.last);
          else pass_cnt++;
          if (obs_r.last === 1'b1) last_cnt++;
          beats++;
          have_prev = 1'b0;
        end else begin
          prev_r    = obs_r;
          have_prev = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    axi_rready_i = 1'b0;
    if (beats <= len) begin
      total_cnt++;
      $display("FAIL r_timeout beats=%0d want %0d", beats, len + 1);
      while (r_q.size() > 0) void'(r_q.pop_front());
    end
    total_cnt++;
    if (last_cnt !== 1) $display("FAIL r_last_count got=%0d want 1", last_cnt);
    else pass_cnt++;
    total_cnt++;
    if (axi_rvalid_o !== 1'b0) $display("FAIL r_valid_after_burst got=%b want 0", axi_rvalid_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    outs_t o;
    #3;
    o = sample_outs();
    total_cnt++;
    if (o !== reset_outs) $display("FAIL reset_async got=%h want=%h", o, reset_outs);
    else pass_cnt++;
    tick();
    tick();
    @(negedge clk);
    reset_i = 1'b0;
    tick();
    o = sample_outs();
    total_cnt++;
    if (o !== reset_outs) $display("FAIL reset_idle got=%h want=%h", o, reset_outs);
    else pass_cnt++;
  endtask

  task automatic test_burst();
    wbeats[0] = 64'h11;
    wbeats[1] = 64'h22;
    wbeats[2] = 64'h33;
    wbeats[3] = 64'h44;
    do_write(32'h40, 3, 6'd5, 8'hFF, 0, 3, 1'b0);
    do_read(32'h40, 3, 6'd9, 1'b0);
  endtask

  task automatic test_strobe();
    wbeats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h28, 0, 6'd1, 8'hFF, 0, 0, 1'b0);
    wbeats[0] = 64'h0;
    do_write(32'h28, 0, 6'd2, 8'h0F, 0, 0, 1'b0);
    total_cnt++;
    if (model_mem[5] !== 64'hFFFF_FFFF_0000_0000)
      $display("FAIL strobe_model got=%h want=ffffffff00000000", model_mem[5]);
    else pass_cnt++;
    do_read(32'h28, 0, 6'd3, 1'b0);
  endtask

  task automatic test_read_stall();
    for (int b = 0; b < 8; b++) wbeats[b] = 64'hA5A5_0000_0000_0000 | (64'(b) << 8) | 64'(b + 1);
    do_write(32'h320, 7, 6'd4, 8'hFF, 0, 7, 1'b0);
    do_read(32'h320, 7, 6'd33, 1'b1);
  endtask

  task automatic test_back_to_back_bhold();
    wbeats[0] = 64'hDEAD_BEEF_0000_0001;
    do_write(32'h600, 0, 6'd10, 8'hFF, 10, 0, 1'b1);
    wbeats[0] = 64'hDEAD_BEEF_0000_0002;
    wbeats[1] = 64'hDEAD_BEEF_0000_0003;
    do_write(32'h608, 1, 6'd11, 8'hFF, 0, 1, 1'b0);
    do_read(32'h600, 2, 6'd12, 1'b0);
  endtask

  task automatic test_wlast_error();
    total_cnt++;
    if (error_o !== 1'b0) $display("FAIL error_before got=%b want 0", error_o);
    else pass_cnt++;
    wbeats[0] = 64'h0BAD_0000_0000_0001;
    wbeats[1] = 64'h0BAD_0000_0000_0002;
    do_write(32'h1000, 1, 6'd20, 8'hFF, 0, 0, 1'b0);
    total_cnt++;
    if (error_o !== 1'b1) $display("FAIL error_set got=%b want 1", error_o);
    else pass_cnt++;
    do_read(32'h1000, 1, 6'd21, 1'b0);
    wbeats[0] = 64'h600D;
    do_write(32'h1010, 0, 6'd22, 8'hFF, 0, 0, 1'b0);
    total_cnt++;
    if (error_o !== 1'b1) $display("FAIL error_sticky got=%b want 1", error_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    outs_t o;
    int    n;
    axi_awid_i    = 6'd30;
    axi_awaddr_i  = 32'h800;
    axi_awlen_i   = 8'd7;
    axi_awvalid_i = 1'b1;
    n = 0;
    while (axi_awready_o !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    axi_awvalid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi_wdata_i  = 64'hC0DE_0000_0000_0000 | 64'(b);
      axi_wstrb_i  = 8'hFF;
      axi_wlast_i  = 1'b0;
      axi_wvalid_i = 1'b1;
      n = 0;
      while (axi_wready_o !== 1'b1 && n < 50) begin tick(); n++; end
      tick();
      model_mem[256 + b] = 64'hC0DE_0000_0000_0000 | 64'(b);
    end
    axi_wdata_i = 64'hC0DE_0000_0000_0002;
    #2;
    reset_i = 1'b1;
    #1;
    o = sample_outs();
    total_cnt++;
    if (o !== reset_outs) $display("FAIL reset_mid_burst got=%h want=%h", o, reset_outs);
    else pass_cnt++;
    axi_wvalid_i = 1'b0;
    tick();
    tick();
    #3;
    reset_i = 1'b0;
    tick();
    do_read(32'h800, 1, 6'd31, 1'b0);
    for (int b = 0; b < 8; b++) wbeats[b] = 64'h5EED_0000_0000_0000 | 64'(b * 3);
    do_write(32'h800, 7, 6'd32, 8'hFF, 0, 7, 1'b0);
    do_read(32'h800, 7, 6'd34, 1'b0);
  endtask

  task automatic test_bounds();
    for (int b = 0; b < 4; b++) wbeats[b] = 64'h0000_1111_0000_0000 | 64'(b);
    do_write(32'h0, 3, 6'd40, 8'hFF, 0, 3, 1'b0);
    for (int b = 0; b < 8; b++) wbeats[b] = 64'hB0B0_0000_0000_0000 | 64'(b + 16);
    do_write(32'h1FE0, 7, 6'd41, 8'hFF, 0, 7, 1'b0);
    do_read(32'h1FE0, 7, 6'd42, 1'b0);
    do_read(32'h0, 3, 6'd43, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_burst();
    test_strobe();
    test_read_stall();
    test_back_to_back_bhold();
    test_wlast_error();
    test_reset_mid_burst();
    test_bounds();
    total_cnt++;
    if (b_q.size() != 0 || r_q.size() != 0)
      $display("FAIL scoreboard_drain b_left=%0d r_left=%0d want 0", b_q.size(), r_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
